instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream fetch stage for the control unit. Prefetches instruction bytes from the shared 8-bit RAM into a small FIFO.
//  Presents the head byte as ibuf with a valid/ready handshake.
//  Fetching yields the RAM port whenever the control unit drives a data access.
//  A redirect (branch/IP load) flushes all prefetched and in-flight bytes.
// PARAMETERS
//  DEPTH        4   prefetch FIFO entries; power of 2, range 2..8
//  RAM_LATENCY  1   cycles from mem_rd_en to mem_rdata valid; range 1..3
// PORTS
//  clk         in   1  single clock; all logic on posedge
//  rst         in   1  synchronous, active-high reset
//  run         in   1  1 = fetch enabled, 0 = stop issuing (drain only)
//  mem_busy    in   1  RAM port held by a data access this cycle; no fetch issue
//  mem_addr    out  8  fetch address
//  mem_rd_en   out  1  fetch read strobe, one byte per cycle
//  mem_rdata   in   8  RAM read data, valid RAM_LATENCY cycles after mem_rd_en
//  ip_load     in   1  redirect strobe
//  ip_target   in   8  redirect address
//  ibuf        out  8  head instruction byte
//  ibuf_valid  out  1  ibuf holds a valid byte
//  ibuf_ready  in   1  consumer accepts ibuf this cycle
//  fetch_ip    out  8  RAM address of the byte currently on ibuf
//  fifo_level  out  4  occupied FIFO entries, 0..DEPTH
// BEHAVIOUR
//  Reset: state=IDLE; fptr=0; FIFO empty; in-flight pipe cleared.
//   Outputs after reset: mem_rd_en=0, mem_addr=0, ibuf=0, ibuf_valid=0, fetch_ip=0, fifo_level=0.
//  FSM states:
//   IDLE->RUN when run=1.
//   RUN->STALL when mem_busy=1, or when credits are exhausted.
//   STALL->RUN when both causes clear.
//   RUN/STALL->IDLE when run=0.
//  Credit rule: issue only if fifo_level + in_flight < DEPTH. The FIFO can never overflow, so no response is ever dropped.
//  Issue: mem_rd_en=1 and mem_addr=fptr in RUN when the credit rule holds and mem_busy=0. fptr then increments.
//   fptr wraps 8'hFF -> 8'h00.
//  In-flight: valid/address shift pipe, RAM_LATENCY deep. Its output pushes {mem_rdata, addr} into the FIFO.
//  Handshake: a pop occurs when ibuf_valid & ibuf_ready.
//   Push and pop in the same cycle are both performed; the level is unchanged.
//   ibuf and fetch_ip are combinational from the FIFO head and hold steady while ibuf_valid & !ibuf_ready.
//  Fetch latency: with an empty FIFO and no stall, ibuf_valid rises RAM_LATENCY+1 cycles after issue.
//  Redirect: ip_load has priority over every other event in that cycle.
//   FIFO cleared, pipe valid bits cleared, fptr <= ip_target.
//   Any issue or pop in that same cycle is suppressed.
//   Issue from ip_target may start the next cycle.
//  run=0: no new issue. In-flight bytes still land, and the FIFO still drains.
//  mem_busy during an in-flight read: that response is still accepted. The RAM is pipelined.
//  rst mid-operation: full reset next edge; in-flight responses discarded.
// CONFIGURATION
//  Macro IFU_PERF_CNT_EN.
//  Defined: adds output stall_cnt[15:0]. It counts cycles in STALL, plus RUN cycles with ibuf_valid=0.
//   Saturates at 16'hFFFF. Cleared by rst only; unaffected by ip_load.
//  Undefined: no port, no counter; otherwise identical.
// STRUCTURE
//  Shared package cpu8_pkg holds:
//   ifu_state_t {IDLE, RUN, STALL}
//   ADDR_W=8, DATA_W=8
//   IFU_RESET_IP=8'h00
//  Sub-module ifu_fifo: DEPTH x 16-bit ({addr, data}) synchronous FIFO.
//   Ports: push/pop/clear plus level. Read is combinational from the head.
//  Top level holds the FSM, credit logic, fptr and latency pipe.
// TESTING
//  1. Reset, run=1, RAM[0..3]=A0..A3, ibuf_ready=1.
//     -> mem_addr 0,1,2,3 on consecutive cycles; ibuf A0 at cycle 2 (RAM_LATENCY=1); fetch_ip tracks 0..3.
//  2. ibuf_ready=0 from start.
//     -> exactly DEPTH=4 issues; fifo_level=4; mem_rd_en=0 thereafter; ibuf stays A0.
//  3. mem_busy=1 for cycles 3..5 mid-stream.
//     -> no issue in those cycles; the byte issued at cycle 2 still arrives; no gaps or duplicates in the ibuf sequence.
//  4. ip_load=1, ip_target=8'h40, with 2 bytes queued and 1 in flight.
//     -> next cycle ibuf_valid=0, fifo_level=0; stale byte never appears; next issue mem_addr=8'h40.
//  5. ip_target=8'hFE, run continuous.
//     -> mem_addr sequence FE, FF, 00, 01; fetch_ip follows it.
//  6. IFU_PERF_CNT_EN defined: hold mem_busy=1 for 10 cycles with an empty FIFO.
//     -> stall_cnt increments 10 (plus empty-RUN cycles); rst returns it to 0.

Source files
------------

// File: rtl/cpu8_pkg.sv
// Shared types and constants for the 8-bit CPU fetch path.
// Contents: ifu_state_t FSM encoding, address/data widths, reset fetch
// address and a saturating 16-bit increment helper.
package cpu8_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] IFU_RESET_IP = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } ifu_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO: DEPTH entries of W bits, synchronous push/pop/clear.
// The head entry is readable combinationally; it is only meaningful while
// level is non-zero.
// Ports: clk, rst (sync, active high), clear (flush), push/push_data,
//        pop, head_data (head entry), level (occupied entries 0..DEPTH).
module ifu_fifo
    import cpu8_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [3:0]   level
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [3:0]       cnt_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && (cnt_r < DEPTH_L);
    assign pop_ok_s  = pop && (cnt_r != 4'd0);
    assign head_data = mem_r[rd_ptr_r];
    assign level     = cnt_r;

    // Pointer and occupancy bookkeeping; clear discards all entries.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= 4'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + 4'd1;
                2'b01:   cnt_r <= cnt_r - 4'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Storage array; contents past the level are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear && !rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: prefetches bytes from the shared 8-bit RAM into a
// small FIFO and presents the head byte to the control unit.
// Ports: clk, rst (sync, active high), run, mem_busy, mem_addr, mem_rd_en,
//        mem_rdata, ip_load, ip_target, ibuf, ibuf_valid, ibuf_ready,
//        fetch_ip, fifo_level; stall_cnt when IFU_PERF_CNT_EN is defined.
// Optional feature macro: IFU_PERF_CNT_EN (stall cycle counter).
module instr_fetch_unit
    import cpu8_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              mem_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ip_load,
    input  logic [ADDR_W-1:0] ip_target,
    output logic [DATA_W-1:0] ibuf,
    output logic              ibuf_valid,
    input  logic              ibuf_ready,
    output logic [ADDR_W-1:0] fetch_ip,
    output logic [3:0]        fifo_level
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    ifu_state_t              state_r;
    ifu_state_t              state_s;
    logic [ADDR_W-1:0]       fptr_r;
    logic [RAM_LATENCY-1:0]  pipe_v_r;
    logic [ADDR_W-1:0]       pipe_a_r [RAM_LATENCY];
    logic [3:0]              in_flight_s;
    logic                    credit_ok_s;
    logic                    issue_s;
    logic                    push_s;
    logic                    pop_s;
    logic [15:0]             head_s;

    // Count reads still travelling through the RAM pipeline.
    always_comb begin
        in_flight_s = 4'd0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            in_flight_s = in_flight_s + {3'd0, pipe_v_r[i]};
        end
    end

    // Reserving FIFO space for in-flight reads means a response never
    // finds the FIFO full.
    assign credit_ok_s = ({1'b0, fifo_level} + {1'b0, in_flight_s}) < DEPTH_L;
    assign issue_s     = (state_r == RUN) && run && !mem_busy && credit_ok_s && !ip_load;
    assign mem_rd_en   = issue_s;
    assign mem_addr    = fptr_r;

    assign push_s     = pipe_v_r[RAM_LATENCY-1] && !ip_load;
    assign ibuf_valid = (fifo_level != 4'd0);
    assign pop_s      = ibuf_valid && ibuf_ready && !ip_load;
    assign ibuf       = ibuf_valid ? head_s[DATA_W-1:0] : 8'h00;
    assign fetch_ip   = ibuf_valid ? head_s[15:8] : 8'h00;

    ifu_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (ip_load),
        .push      (push_s),
        .push_data ({pipe_a_r[RAM_LATENCY-1], mem_rdata}),
        .pop       (pop_s),
        .head_data (head_s),
        .level     (fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!run) begin
                    state_s = IDLE;
                end else if (mem_busy || !credit_ok_s) begin
                    state_s = STALL;
                end else begin
                    state_s = RUN;
                end
            end
            STALL: begin
                if (!run) begin
                    state_s = IDLE;
                end else if (!mem_busy && credit_ok_s) begin
                    state_s = RUN;
                end else begin
                    state_s = STALL;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Fetch pointer: redirect wins over the post-issue increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            fptr_r <= IFU_RESET_IP;
        end else if (ip_load) begin
            fptr_r <= ip_target;
        end else if (issue_s) begin
            fptr_r <= fptr_r + 8'd1;
        end
    end

    // Valid/address shift pipe matching the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst || ip_load) begin
            pipe_v_r <= '0;
        end else begin
            pipe_v_r[0] <= issue_s;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
            end
        end
    end

    // Address half of the pipe; only meaningful alongside its valid bit.
    always_ff @(posedge clk) begin
        pipe_a_r[0] <= fptr_r;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_a_r[i] <= pipe_a_r[i-1];
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cnt_r;
    assign stall_cnt = stall_cnt_r;

    // Cycles lost to stalls or to an empty buffer while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == STALL) || ((state_r == RUN) && !ibuf_valid)) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=4, RAM_LATENCY=1).
// The RAM model returns addr + 8'hA0, so RAM[0..3] = A0..A3.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mem_busy;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata = 8'h00;
    logic       ip_load;
    logic [7:0] ip_target;
    logic [7:0] ibuf;
    logic       ibuf_valid;
    logic       ibuf_ready;
    logic [7:0] fetch_ip;
    logic [3:0] fifo_level;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    instr_fetch_unit #(.DEPTH(4), .RAM_LATENCY(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_busy   (mem_busy),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .ip_load    (ip_load),
        .ip_target  (ip_target),
        .ibuf       (ibuf),
        .ibuf_valid (ibuf_valid),
        .ibuf_ready (ibuf_ready),
        .fetch_ip   (fetch_ip),
        .fifo_level (fifo_level)
`ifdef IFU_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM model.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem_addr + 8'hA0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; mem_busy = 1'b0; ip_load = 1'b0;
        ip_target = 8'h00; ibuf_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int idx;
        logic [7:0] a;

        // Test 1: streaming fetch from reset
        do_reset();
        run = 1'b1; ibuf_ready = 1'b1;
        @(negedge clk);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ibuf", ibuf, 0);
        chk("rst_valid", ibuf_valid, 0);
        chk("rst_fetch_ip", fetch_ip, 0);
        chk("rst_level", fifo_level, 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            @(negedge clk);
            chk("t1_rd_en", mem_rd_en, 1);
            chk("t1_addr", mem_addr, i);
            if (i >= 2) begin
                chk("t1_valid", ibuf_valid, 1);
                chk("t1_ibuf", ibuf, 8'hA0 + i - 2);
                chk("t1_fetch_ip", fetch_ip, i - 2);
            end
        end

        // Test 2: consumer never ready, credits stop issue at DEPTH
        do_reset();
        run = 1'b1; ibuf_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_rd_en) n++;
            cyc();
        end
        @(negedge clk);
        chk("t2_issues", n, 4);
        chk("t2_level", fifo_level, 4);
        chk("t2_rd_en", mem_rd_en, 0);
        chk("t2_ibuf", ibuf, 8'hA0);
        chk("t2_fetch_ip", fetch_ip, 0);

        // Test 3: mem_busy in cycles 3..5
        do_reset();
        run = 1'b1; ibuf_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 15; c++) begin
            mem_busy = (c >= 3 && c <= 5);
            @(negedge clk);
            if (mem_busy) chk("t3_busy_no_issue", mem_rd_en, 0);
            if (c == 4) chk("t3_inflight_lands", ibuf, 8'hA1);
            if (ibuf_valid && ibuf_ready) begin
                chk("t3_seq_ibuf", ibuf, 8'hA0 + idx);
                chk("t3_seq_ip", fetch_ip, idx);
                idx++;
            end
            cyc();
        end
        mem_busy = 1'b0;
        chk("t3_pop_count", idx, 8);

        // Test 4: redirect with 2 queued and 1 in flight
        do_reset();
        run = 1'b1; ibuf_ready = 1'b0;
        repeat (4) cyc();
        ip_load = 1'b1; ip_target = 8'h40;
        @(negedge clk);
        chk("t4_level_before", fifo_level, 2);
        chk("t4_issue_suppressed", mem_rd_en, 0);
        cyc();
        ip_load = 1'b0; ibuf_ready = 1'b1;
        @(negedge clk);
        chk("t4_valid_cleared", ibuf_valid, 0);
        chk("t4_level_cleared", fifo_level, 0);
        chk("t4_new_issue", mem_rd_en, 1);
        chk("t4_new_addr", mem_addr, 8'h40);
        cyc();
        @(negedge clk);
        chk("t4_no_stale", ibuf_valid, 0);
        cyc();
        @(negedge clk);
        chk("t4_first_valid", ibuf_valid, 1);
        chk("t4_first_ibuf", ibuf, 8'hE0);
        chk("t4_first_ip", fetch_ip, 8'h40);

        // Test 5: fetch pointer wraps FF -> 00
        do_reset();
        run = 1'b1; ibuf_ready = 1'b1; ip_load = 1'b1; ip_target = 8'hFE;
        cyc();
        ip_load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 4) begin
                a = 8'hFE + 8'(i);
                chk("t5_addr", mem_addr, a);
                chk("t5_rd_en", mem_rd_en, 1);
            end
            if (i >= 2) begin
                a = 8'hFE + 8'(i - 2);
                chk("t5_fetch_ip", fetch_ip, a);
                a = a + 8'hA0;
                chk("t5_ibuf", ibuf, a);
            end
            cyc();
        end

`ifdef IFU_PERF_CNT_EN
        // Test 6: stall counter
        do_reset();
        run = 1'b1; mem_busy = 1'b1;
        repeat (10) cyc();
        mem_busy = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("t6_stall_cnt_busy", stall_cnt, 9);
        cyc();
        cyc();
        @(negedge clk);
        chk("t6_stall_cnt_idle", stall_cnt, 10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_stall_cnt_rst", stall_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
